// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus between the score/game logic and the seven-segment scan controller.
//   i_VALUE      packed nibbles, digit 0 in [3:0]
//   i_LOAD       1-cycle strobe capturing i_VALUE into the staging register
//   o_LOAD_ACK   1-cycle pulse when staging is committed to the display register
//   o_BINARY     nibble for the shared binary-to-7seg decoder
//   o_DIGIT_EN   one-hot active-high digit enable, or all zero
//   o_FRAME_DONE 1-cycle pulse after the last digit's slot completes
// master: value producer; slave: scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_VALUE;
  logic                    i_LOAD;
  logic                    o_LOAD_ACK;
  logic [3:0]              o_BINARY;
  logic [NUM_DIGITS-1:0]   o_DIGIT_EN;
  logic                    o_FRAME_DONE;

  modport master (
    output i_VALUE,
    output i_LOAD,
    input  o_LOAD_ACK,
    input  o_BINARY,
    input  o_DIGIT_EN,
    input  o_FRAME_DONE
  );

  modport slave (
    input  i_VALUE,
    input  i_LOAD,
    output o_LOAD_ACK,
    output o_BINARY,
    output o_DIGIT_EN,
    output o_FRAME_DONE
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-select 7-seg display.
// One decoder is shared across NUM_DIGITS digits. Each slot starts with BLANK_CLKS
// dead-time clocks (enables off, nibble already presented) followed by the drive phase.
// Loaded values are double-buffered and committed only at frame boundaries.
// Ports:
//   i_CLK  system clock, rising edge
//   i_RST  synchronous active-high reset
//   bus    seven_seg_scan_ctrl_if.slave (value/load in, decoder nibble, enables, pulses out)
// Optional feature macro: LEADING_ZERO_BLANK_EN -- when defined, digits above digit 0 whose
// nibble and all higher nibbles are zero keep their enable low during the drive phase.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLKS_PER_DIGIT = 6250,
  parameter int unsigned BLANK_CLKS     = 25
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_DIGIT);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam int unsigned ValW = 4 * NUM_DIGITS;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CLKS - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(CLKS_PER_DIGIT - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ValW-1:0]       display_q, display_d;
  logic [ValW-1:0]       staging_q, staging_d;
  logic                  pending_q, pending_d;
  logic [3:0]            binary_q, binary_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  ack_q, ack_d;
  logic                  fd_q, fd_d;
  logic                  wrap, commit;
  logic [NUM_DIGITS-1:0] blank_mask;

  // Slot sequencing and load/commit bookkeeping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    display_d = display_q;
    staging_d = staging_q;
    pending_d = pending_q;
    wrap      = 1'b0;
    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) state_d = StDrive;
      end
      StDrive: begin
        if (cnt_q == SlotLast) begin
          state_d = StBlank;
          cnt_d   = '0;
          if (idx_q == IdxLast) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StBlank;
    endcase
    commit = wrap & pending_q;
    if (commit) begin
      display_d = staging_q;
      pending_d = 1'b0;
    end
    // Applied after the commit so a load in the boundary cycle stays pending for next frame.
    if (bus.i_LOAD) begin
      staging_d = bus.i_VALUE;
      pending_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  // Mask follows the value being displayed, so it changes only at a commit.
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (display_d[4*k +: 4] == 4'h0);
      blank_mask[k] = zero_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Outputs are registered from next-state so they line up with the slot they describe.
  always_comb begin
    binary_d = display_d[4*idx_d +: 4];
    en_d     = '0;
    if (state_d == StDrive && !blank_mask[idx_d]) en_d = NUM_DIGITS'(1) << idx_d;
    ack_d    = commit;
    fd_d     = wrap;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= StBlank;
      cnt_q     <= '0;
      idx_q     <= '0;
      display_q <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      binary_q  <= '0;
      en_q      <= '0;
      ack_q     <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      binary_q  <= binary_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
      fd_q      <= fd_d;
    end
  end

  assign bus.o_BINARY     = binary_q;
  assign bus.o_DIGIT_EN   = en_q;
  assign bus.o_LOAD_ACK   = ack_q;
  assign bus.o_FRAME_DONE = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (4 digits, 8 clocks/slot, 2 blank clocks).
module tb_seven_seg_scan_ctrl;
  localparam int unsigned ND    = 4;
  localparam int unsigned CPD   = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * CPD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS    (ND),
    .CLKS_PER_DIGIT(CPD),
    .BLANK_CLKS    (BC)
  ) dut (
    .i_CLK(clk),
    .i_RST(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] bin;
  } slot_t;

  slot_t slot_q[$];
  bit    ack_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    scyc     = 0;
  int    mcyc     = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
    end
  endtask

  function automatic bit visible(input logic [15:0] v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    logic [15:0] hi;
    if (k == 0) return 1'b1;
    hi = v >> (4 * k);
    return hi != 16'h0;
`else
    return (k >= 0);
`endif
  endfunction

  task automatic push_slot(input int k, input logic [15:0] v);
    slot_t s;
    if (visible(v, k)) begin
      s.en  = 4'(1 << k);
      s.bin = v[4*k +: 4];
      slot_q.push_back(s);
    end
  endtask

  task automatic push_frame(input logic [15:0] v, input bit ack);
    for (int k = 0; k < int'(ND); k++) push_slot(k, v);
    ack_q.push_back(ack);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    scyc++;
  endtask

  task automatic run_to(input int c);
    while (scyc < c) step();
  endtask

  task automatic load_at(input int c, input logic [15:0] v);
    run_to(c);
    bus.i_LOAD  = 1'b1;
    bus.i_VALUE = v;
    step();
    bus.i_LOAD  = 1'b0;
    bus.i_VALUE = 16'hDEAD;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    scyc = 0;
  endtask

  task automatic end_test(input string name);
    @(negedge clk);
    #1;
    check({name, "_slots_left"}, slot_q.size(), 0);
    check({name, "_frames_left"}, ack_q.size(), 0);
    slot_q.delete();
    ack_q.delete();
  endtask

  // Monitor: pops expected slot at each drive start and expected ACK at each frame pulse.
  initial begin
    int         pos;
    logic [3:0] prev_en;
    logic [3:0] prev_bin;
    slot_t      s;
    bit         a;
    prev_en  = '0;
    prev_bin = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mcyc    = 0;
        prev_en = '0;
        continue;
      end
      pos = mcyc % int'(CPD);
      if (mcyc == 0) begin
        check("reset_binary", int'(bus.o_BINARY), 0);
        check("reset_en", int'(bus.o_DIGIT_EN), 0);
        check("reset_ack", int'(bus.o_LOAD_ACK), 0);
        check("reset_frame_done", int'(bus.o_FRAME_DONE), 0);
      end else if (pos < int'(BC)) begin
        check("blank_gap_en", int'(bus.o_DIGIT_EN), 0);
      end else if (pos == int'(BC)) begin
        if (bus.o_DIGIT_EN != 4'h0) begin
          if (slot_q.size() == 0) begin
            check("slot_unexpected", int'(bus.o_DIGIT_EN), 0);
          end else begin
            s = slot_q.pop_front();
            check("slot_en", int'(bus.o_DIGIT_EN), int'(s.en));
            check("slot_binary", int'(bus.o_BINARY), int'(s.bin));
          end
        end
      end else begin
        check("en_hold", int'(bus.o_DIGIT_EN), int'(prev_en));
        check("binary_hold", int'(bus.o_BINARY), int'(prev_bin));
      end
      if (bus.o_FRAME_DONE) begin
        check("frame_period", int'(mcyc % int'(FRAME) == 0 && mcyc != 0), 1);
        if (ack_q.size() == 0) begin
          check("frame_done_unexpected", 1, 0);
        end else begin
          a = ack_q.pop_front();
          check("load_ack", int'(bus.o_LOAD_ACK), int'(a));
        end
      end else begin
        check("ack_without_frame_done", int'(bus.o_LOAD_ACK), 0);
      end
      prev_en  = bus.o_DIGIT_EN;
      prev_bin = bus.o_BINARY;
      mcyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_LOAD  = 1'b0;
    bus.i_VALUE = 16'h0;

    // Reset then idle: two frames of zeros, no ACK.
    do_reset(3);
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0000, 1'b0);
    run_to(64);
    end_test("idle");

    // Single load committed at frame end, shown 4,3,2,1.
    do_reset(1);
    push_frame(16'h0000, 1'b1);
    push_frame(16'h1234, 1'b0);
    load_at(5, 16'h1234);
    run_to(64);
    end_test("single_load");

    // Last write wins, one ACK; shown 7,C,0,0.
    do_reset(1);
    push_frame(16'h0000, 1'b1);
    push_frame(16'h00C7, 1'b0);
    load_at(3, 16'hAAAA);
    load_at(20, 16'h00C7);
    run_to(64);
    end_test("overwrite");

    // Load on the boundary cycle is committed one frame later.
    do_reset(1);
    push_frame(16'h0000, 1'b1);
    push_frame(16'h1111, 1'b1);
    push_frame(16'h5555, 1'b0);
    load_at(5, 16'h1111);
    load_at(31, 16'h5555);
    run_to(96);
    end_test("boundary_load");

    // Reset during digit 2 drive discards the pending load.
    do_reset(1);
    push_frame(16'h0000, 1'b1);
    load_at(5, 16'h1234);
    push_slot(0, 16'h1234);
    push_slot(1, 16'h1234);
    push_slot(2, 16'h1234);
    load_at(37, 16'hFFFF);
    run_to(52);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    scyc = 0;
    push_frame(16'h0000, 1'b0);
    run_to(32);
    end_test("mid_reset");

    // Values with zero high nibbles.
    do_reset(1);
    push_frame(16'h0000, 1'b1);
    push_frame(16'h0305, 1'b1);
    push_frame(16'h0005, 1'b0);
    load_at(10, 16'h0305);
    load_at(40, 16'h0005);
    run_to(96);
    end_test("leading_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
